// File: rtl/coo_agg_pkg.sv
// Shared types and default sizes for the COO aggregation scheduler.
// The COO_FWD_EN macro (see coo_hazard_unit) switches hazard handling from stall to forward.
package coo_agg_pkg;

    localparam int NUM_EDGES = 7;
    localparam int NUM_NODES = 6;
    localparam int NODE_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // valid marks an in-range edge that must be aggregated
    typedef struct packed {
        logic              valid;
        logic [NODE_W-1:0] dst;
        logic [NODE_W-1:0] src;
    } stage_t;

endpackage

// File: rtl/coo_hazard_unit.sv
// Accumulator read-after-write detector between the read-add and write stages.
// COO_FWD_EN defined: a hit requests forwarding; otherwise a hit requests a stall.
module coo_hazard_unit
    import coo_agg_pkg::*;
(
    input  stage_t s2,
    input  stage_t s3,
    output logic   stall,
    output logic   fwd
);

    logic hit;

    // same accumulator row being read in S2 while S3 writes it
    always_comb begin
        hit = 1'b0;
        if (s2.valid && s3.valid && (s2.dst == s3.dst)) begin
            hit = 1'b1;
        end else begin
            hit = 1'b0;
        end
`ifdef COO_FWD_EN
        stall = 1'b0;
        fwd   = hit;
`else
        stall = hit;
        fwd   = 1'b0;
`endif
    end

endmodule

// File: rtl/coo_agg_scheduler.sv
// Edge-list walker for neighbour aggregation: fetch / read-add / write pipeline.
// Optional macro COO_FWD_EN replaces the hazard stall with sum-register forwarding.
module coo_agg_scheduler
    import coo_agg_pkg::*;
#(
    parameter int NUM_EDGES = coo_agg_pkg::NUM_EDGES,
    parameter int NUM_NODES = coo_agg_pkg::NUM_NODES,
    parameter int NODE_W    = coo_agg_pkg::NODE_W,
    parameter int ADDR_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] coo_addr,
    input  logic [NODE_W-1:0] coo_in [0:1],
    output logic [NODE_W-1:0] fm_rd_row,
    output logic [NODE_W-1:0] acc_rd_row,
    output logic              sum_ld,
    output logic              fwd_sel,
    output logic              acc_wr_en,
    output logic [NODE_W-1:0] acc_wr_row,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            state;
    logic [ADDR_W-1:0] k;
    logic              fetch_done;
    stage_t            s2;
    logic              s2_occ;
    stage_t            s3;
    logic              err_r;
    logic              stall;
    logic              fwd;
    logic              in_range;

    coo_hazard_unit u_hazard (
        .s2    (s2),
        .s3    (s3),
        .stall (stall),
        .fwd   (fwd)
    );

    // out-of-range edges travel as occupied-but-invalid slots so timing is unchanged
    always_comb begin
        in_range = (coo_in[0] < NODE_W'(NUM_NODES)) && (coo_in[1] < NODE_W'(NUM_NODES));
    end

    // control FSM, edge pointer and pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            k          <= '0;
            fetch_done <= 1'b0;
            s2         <= '0;
            s2_occ     <= 1'b0;
            s3         <= '0;
            err_r      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    s2     <= '0;
                    s2_occ <= 1'b0;
                    s3     <= '0;
                    if (start) begin
                        state      <= ST_RUN;
                        k          <= '0;
                        fetch_done <= 1'b0;
                        err_r      <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        s3 <= s2;
                        if (!fetch_done) begin
                            s2     <= '{valid: in_range, dst: coo_in[0], src: coo_in[1]};
                            s2_occ <= 1'b1;
                            if (!in_range) begin
                                err_r <= 1'b1;
                            end else begin
                                err_r <= err_r;
                            end
                            // pointer parks on the last edge, no wrap
                            if (k == ADDR_W'(NUM_EDGES - 1)) begin
                                fetch_done <= 1'b1;
                            end else begin
                                k <= k + ADDR_W'(1);
                            end
                        end else begin
                            s2     <= '0;
                            s2_occ <= 1'b0;
                        end
                    end else begin
                        s3 <= '0;
                    end
                    // S3 drains on this edge, so only S2 needs to be empty
                    if (fetch_done && !s2_occ) begin
                        state <= ST_DONE;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    s3    <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // address, enable and select decode from the stage registers
    always_comb begin
        coo_addr   = (state == ST_RUN) ? k : '0;
        fm_rd_row  = s2.valid ? s2.src : '0;
        acc_rd_row = s2.valid ? s2.dst : '0;
        sum_ld     = s2.valid && !stall;
        fwd_sel    = fwd;
        acc_wr_en  = s3.valid;
        acc_wr_row = s3.valid ? s3.dst : '0;
        busy       = (state == ST_RUN);
        done       = (state == ST_DONE);
        err        = err_r;
    end

endmodule
